// File: rtl/quad_pkg.sv
// Shared encodings for the quadrature step decoder.
// Holds direction levels, Gray codes, FSM states and the transition classifier.
package quad_pkg;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    localparam logic [1:0] Q00 = 2'b00;
    localparam logic [1:0] Q01 = 2'b01;
    localparam logic [1:0] Q11 = 2'b11;
    localparam logic [1:0] Q10 = 2'b10;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    typedef enum logic [1:0] {
        TR_NONE,
        TR_FWD,
        TR_REV,
        TR_ERR
    } trans_e;

    function automatic trans_e quad_decode(
        input logic [1:0] prev,
        input logic [1:0] cur
    );
        logic [1:0] fwd;
        trans_e     tr;
        unique case (prev)
            Q00:     fwd = Q01;
            Q01:     fwd = Q11;
            Q11:     fwd = Q10;
            default: fwd = Q00;
        endcase
        if (cur == prev)
            tr = TR_NONE;
        else if (cur == fwd)
            tr = TR_FWD;
        else if ((cur ^ prev) == 2'b11)
            tr = TR_ERR;
        else
            tr = TR_REV;
        return tr;
    endfunction

endpackage

// File: rtl/quad_glitch_filter.sv
// Per-channel synchroniser plus stability filter.
// The filtered level follows only after FILTER_LEN cycles of disagreement.
module quad_glitch_filter
    import quad_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    input  logic load,
    output logic filt
);

    localparam int CW = $clog2(FILTER_LEN + 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   filt_q, filt_d;
    logic                   synced;

    assign synced = sync_q[SYNC_STAGES-1];
    assign filt   = filt_q;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], raw};
        cnt_d  = '0;
        filt_d = filt_q;
        // load bypasses the stability count while the decoder settles
        if (load) begin
            filt_d = synced;
        end else if (synced != filt_q) begin
            if (cnt_q == CW'(FILTER_LEN - 1))
                filt_d = synced;
            else
                cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            cnt_q  <= '0;
            filt_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            cnt_q  <= cnt_d;
            filt_q <= filt_d;
        end
    end

endmodule

// File: rtl/quadrature_step_decoder.sv
// Quadrature A/B front end producing Step pulses and an UpDown level.
// Illegal double-channel jumps raise Error and bump a saturating count.
module quadrature_step_decoder
    import quad_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 4,
    parameter int ERR_W       = 8
) (
    input  logic             Clk,
    input  logic             reset_n,
    input  logic             EncA,
    input  logic             EncB,
    input  logic             Enable,
    input  logic             ErrClear,
    output logic             Step,
    output logic             UpDown,
    output logic             Error,
    output logic [ERR_W-1:0] ErrCount
);

    localparam int INIT_CYC = SYNC_STAGES + FILTER_LEN;
    localparam int IW       = $clog2(INIT_CYC + 1);

    state_e           state_q, state_d;
    logic [IW-1:0]    init_q, init_d;
    logic [1:0]       prev_q, prev_d;
    logic             step_q, step_d;
    logic             error_q, error_d;
    logic             updown_q, updown_d;
    logic [ERR_W-1:0] errcnt_q, errcnt_d;
    logic             a_f, b_f, load;
    logic [1:0]       cur;
    trans_e           tr;

    assign load = (state_q == ST_INIT);
    assign cur  = {a_f, b_f};

    quad_glitch_filter #(
        .SYNC_STAGES (SYNC_STAGES),
        .FILTER_LEN  (FILTER_LEN)
    ) u_filt_a (
        .clk   (Clk),
        .rst_n (reset_n),
        .raw   (EncA),
        .load  (load),
        .filt  (a_f)
    );

    quad_glitch_filter #(
        .SYNC_STAGES (SYNC_STAGES),
        .FILTER_LEN  (FILTER_LEN)
    ) u_filt_b (
        .clk   (Clk),
        .rst_n (reset_n),
        .raw   (EncB),
        .load  (load),
        .filt  (b_f)
    );

    always_comb begin
        state_d  = state_q;
        init_d   = init_q;
        prev_d   = cur;
        step_d   = 1'b0;
        error_d  = 1'b0;
        updown_d = updown_q;
        errcnt_d = errcnt_q;
        tr       = quad_decode(prev_q, cur);
        unique case (state_q)
            ST_INIT: begin
                if (init_q == IW'(INIT_CYC - 1)) begin
                    state_d = ST_RUN;
                    init_d  = '0;
                end else begin
                    init_d = init_q + 1'b1;
                end
            end
            ST_RUN: begin
                // disabled: prev keeps tracking so re-enable is clean
                if (Enable) begin
                    unique case (tr)
                        TR_FWD: begin
                            step_d   = 1'b1;
                            updown_d = DIR_UP;
                        end
                        TR_REV: begin
                            step_d   = 1'b1;
                            updown_d = DIR_DOWN;
                        end
                        TR_ERR: begin
                            error_d = 1'b1;
                            if (errcnt_q != '1)
                                errcnt_d = errcnt_q + 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
        endcase
        if (ErrClear)
            errcnt_d = '0;
    end

    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_INIT;
            init_q   <= '0;
            prev_q   <= '0;
            step_q   <= 1'b0;
            error_q  <= 1'b0;
            updown_q <= DIR_UP;
            errcnt_q <= '0;
        end else begin
            state_q  <= state_d;
            init_q   <= init_d;
            prev_q   <= prev_d;
            step_q   <= step_d;
            error_q  <= error_d;
            updown_q <= updown_d;
            errcnt_q <= errcnt_d;
        end
    end

    assign Step     = step_q;
    assign Error    = error_q;
    assign UpDown   = updown_q;
    assign ErrCount = errcnt_q;

endmodule

// File: tb/tb_quadrature_step_decoder.sv
// Directed plus randomized bench for quadrature_step_decoder.
// Model tracks encoder position as a Gray index and classifies moves by modular delta.
module tb_quadrature_step_decoder;

    localparam int SS  = 2;
    localparam int FL  = 4;
    localparam int EW  = 8;
    localparam int LAT = SS + FL + 1;
    localparam int WIN = 10;
    localparam int SAT = (1 << EW) - 1;

    logic          Clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          EncA = 1'b1;
    logic          EncB = 1'b1;
    logic          Enable = 1'b1;
    logic          ErrClear = 1'b0;
    logic          Step, UpDown, Error;
    logic [EW-1:0] ErrCount;

    int n_vec = 0;
    int n_err = 0;
    int m_pos;
    bit m_dir;
    int m_err;
    int cnt5;
    int tot;

    quadrature_step_decoder #(
        .SYNC_STAGES (SS),
        .FILTER_LEN  (FL),
        .ERR_W       (EW)
    ) dut (
        .Clk      (Clk),
        .reset_n  (reset_n),
        .EncA     (EncA),
        .EncB     (EncB),
        .Enable   (Enable),
        .ErrClear (ErrClear),
        .Step     (Step),
        .UpDown   (UpDown),
        .Error    (Error),
        .ErrCount (ErrCount)
    );

    always #5 Clk = ~Clk;

    function automatic int gidx(input logic a, input logic b);
        return (a ? 2 : 0) + ((a ^ b) ? 1 : 0);
    endfunction

    task automatic check(input string tag,
                         input logic [31:0] obs,
                         input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic run_edge(input string tag, input int idx,
                            input logic en, input bit clr,
                            output int steps);
        int  d, errs, lat;
        bit  x_step, x_err;
        logic a, b;
        a = (idx >= 2);
        b = a ^ ((idx & 1) != 0);
        d = (idx - m_pos) & 3;
        x_step = en && (d == 1 || d == 3);
        x_err  = en && (d == 2);
        @(negedge Clk);
        EncA = a;
        EncB = b;
        Enable = en;
        steps = 0;
        errs = 0;
        lat = 0;
        for (int i = 1; i <= WIN; i++) begin
            @(posedge Clk);
            @(negedge Clk);
            if (Step === 1'b1) begin
                steps++;
                if (lat == 0) lat = i;
            end
            if (Error === 1'b1) begin
                errs++;
                if (lat == 0) lat = i;
            end
            ErrClear = clr && (i == LAT - 1);
        end
        m_pos = idx;
        if (x_step) m_dir = (d == 1);
        if (x_err && m_err < SAT) m_err++;
        if (clr) m_err = 0;
        check({tag, ".steps"}, steps, x_step);
        check({tag, ".errs"}, errs, x_err);
        if (x_step || x_err) check({tag, ".lat"}, lat, LAT);
        check({tag, ".updown"}, UpDown, m_dir);
        check({tag, ".errcnt"}, ErrCount, m_err);
    endtask

    task automatic glitch(input string tag, input bit on_b, input int len);
        int ev;
        @(negedge Clk);
        if (on_b) EncB = ~EncB; else EncA = ~EncA;
        repeat (len) @(negedge Clk);
        if (on_b) EncB = ~EncB; else EncA = ~EncA;
        ev = 0;
        repeat (12) begin
            @(negedge Clk);
            if (Step === 1'b1 || Error === 1'b1) ev++;
        end
        check({tag, ".events"}, ev, 0);
        check({tag, ".errcnt"}, ErrCount, m_err);
    endtask

    initial begin
        int s, ev, pre;
        m_err = 0;
        m_dir = 1'b1;
        repeat (3) @(negedge Clk);
        check("rst.step", Step, 0);
        check("rst.error", Error, 0);
        check("rst.updown", UpDown, 1);
        check("rst.errcnt", ErrCount, 0);

        reset_n = 1'b1;
        ev = 0;
        repeat (20) begin
            @(negedge Clk);
            if (Step === 1'b1 || Error === 1'b1) ev++;
        end
        check("init.events", ev, 0);
        check("init.updown", UpDown, 1);
        m_pos = gidx(1'b1, 1'b1);

        run_edge("init_prev11", gidx(1'b1, 1'b0), 1'b1, 1'b0, s);
        run_edge("to00", gidx(1'b0, 1'b0), 1'b1, 1'b0, s);

        tot = 0;
        for (int k = 1; k <= 4; k++) begin
            run_edge("fwd", k & 3, 1'b1, 1'b0, s);
            tot += s;
        end
        check("fwd.total", tot, 4);

        cnt5 = 5;
        for (int k = 3; k >= 0; k--) begin
            run_edge("rev", k, 1'b1, 1'b0, s);
            cnt5 += (UpDown === 1'b1) ? s : -s;
        end
        check("rev.counter", cnt5, 1);

        glitch("glitchA", 1'b0, FL - 1);
        run_edge("post_glitch", 1, 1'b1, 1'b0, s);
        run_edge("back00", 0, 1'b1, 1'b0, s);

        run_edge("err1", gidx(1'b1, 1'b1), 1'b1, 1'b0, s);
        for (int k = 0; k < 300; k++)
            run_edge("errsat", (k % 2 == 0) ? 0 : 2, 1'b1, 1'b0, s);
        check("errsat.final", ErrCount, SAT);
        run_edge("errclr", 0, 1'b1, 1'b1, s);

        tot = 0;
        for (int k = 1; k <= 3; k++) begin
            run_edge("dis", k, 1'b0, 1'b0, s);
            tot += s;
        end
        check("dis.total", tot, 0);
        run_edge("reen", 0, 1'b1, 1'b0, s);
        check("reen.steps", s, 1);

        for (int k = 0; k < 60; k++) begin
            if ($urandom_range(0, 9) == 0)
                glitch("rnd_glitch", $urandom_range(0, 1) == 1,
                       $urandom_range(1, FL - 1));
            else
                run_edge("rnd", $urandom_range(0, 3),
                         $urandom_range(0, 4) != 0,
                         $urandom_range(0, 9) == 0, s);
        end

        run_edge("mid_err", (m_pos + 2) & 3, 1'b1, 1'b0, s);
        run_edge("mid_rev", (m_pos + 3) & 3, 1'b1, 1'b0, s);
        pre = (m_pos + 3) & 3;
        @(negedge Clk);
        EncA = (pre >= 2);
        EncB = (pre >= 2) ^ ((pre & 1) != 0);
        repeat (LAT) @(negedge Clk);
        check("mid.step_hi", Step, 1);
        #1 reset_n = 1'b0;
        #1;
        check("mid.step", Step, 0);
        check("mid.error", Error, 0);
        check("mid.updown", UpDown, 1);
        check("mid.errcnt", ErrCount, 0);
        repeat (3) @(negedge Clk);
        reset_n = 1'b1;
        ev = 0;
        repeat (15) begin
            @(negedge Clk);
            if (Step === 1'b1 || Error === 1'b1) ev++;
        end
        check("rerun.events", ev, 0);
        m_pos = pre;
        m_dir = 1'b1;
        m_err = 0;
        run_edge("rerun_rev", (m_pos + 3) & 3, 1'b1, 1'b0, s);
        run_edge("rerun_fwd", (m_pos + 1) & 3, 1'b1, 1'b0, s);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
